// File: rtl/bank_read_router.sv
// Routes 16 lane-ordered (bank, address) pairs to per-bank read strobes and
// permutes the returned bank words back into lane order.
module bank_read_router #(
   parameter int LANES  = 16,
   parameter int BANK_W = 4,
   parameter int MA_W   = 6,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     BN_MA_in_en,
   input  logic [LANES*MA_W-1:0]    MA_idx_in,
   input  logic [LANES*BANK_W-1:0]  BN_idx_in,
   input  logic                     AGU_done_in,
   input  logic [2:0]               l_in,
   input  logic                     clr,
   output logic [LANES-1:0]         bank_rd_en,
   output logic [LANES*MA_W-1:0]    bank_addr,
   input  logic [LANES*DATA_W-1:0]  bank_rdata,
   output logic [LANES*DATA_W-1:0]  lane_data,
   output logic                     lane_valid,
   output logic [2:0]               l_out,
   output logic                     done_out,
   output logic                     conflict_err,
   output logic [15:0]              beat_cnt
);

   logic [LANES-1:0]        req_en_c;
   logic [LANES*MA_W-1:0]   req_addr_c;
   logic                    dup_c;
   logic [LANES*DATA_W-1:0] lane_mux_c;

   // Lane map travels alongside the request until the bank data returns.
   logic                    pipe_en   [RD_LAT+1];
   logic [LANES*BANK_W-1:0] pipe_bn   [RD_LAT+1];
   logic [2:0]              pipe_l    [RD_LAT+1];
   logic                    pipe_done [RD_LAT+1];

   // Lanes are scanned from high to low so the lowest-numbered lane
   // targeting a bank is the one whose address survives.
   always_comb begin
      req_en_c   = '0;
      req_addr_c = '0;
      dup_c      = 1'b0;
      for (int b = 0; b < LANES; b++) begin
         for (int i = LANES - 1; i >= 0; i--) begin
            if (BN_idx_in[i*BANK_W +: BANK_W] == BANK_W'(b)) begin
               req_en_c[b]                = 1'b1;
               req_addr_c[b*MA_W +: MA_W] = MA_idx_in[i*MA_W +: MA_W];
            end
         end
      end
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (BN_idx_in[i*BANK_W +: BANK_W] == BN_idx_in[j*BANK_W +: BANK_W])
               dup_c = 1'b1;
         end
      end
   end

   always_comb begin
      lane_mux_c = '0;
      for (int i = 0; i < LANES; i++) begin
         for (int b = 0; b < LANES; b++) begin
            if (pipe_bn[RD_LAT][i*BANK_W +: BANK_W] == BANK_W'(b))
               lane_mux_c[i*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_rd_en <= '0;
         bank_addr  <= '0;
         for (int k = 0; k <= RD_LAT; k++) begin
            pipe_en[k]   <= 1'b0;
            pipe_bn[k]   <= '0;
            pipe_l[k]    <= '0;
            pipe_done[k] <= 1'b0;
         end
      end else begin
         bank_rd_en   <= BN_MA_in_en ? req_en_c : '0;
         bank_addr    <= BN_MA_in_en ? req_addr_c : '0;
         pipe_en[0]   <= BN_MA_in_en;
         pipe_bn[0]   <= BN_idx_in;
         pipe_l[0]    <= l_in;
         pipe_done[0] <= AGU_done_in;
         for (int k = 1; k <= RD_LAT; k++) begin
            pipe_en[k]   <= pipe_en[k-1];
            pipe_bn[k]   <= pipe_bn[k-1];
            pipe_l[k]    <= pipe_l[k-1];
            pipe_done[k] <= pipe_done[k-1];
         end
      end
   end

   // lane_data is only loaded on valid beats so it holds between groups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_data  <= '0;
         lane_valid <= 1'b0;
         l_out      <= '0;
         done_out   <= 1'b0;
      end else begin
         lane_valid <= pipe_en[RD_LAT];
         l_out      <= pipe_l[RD_LAT];
         done_out   <= pipe_done[RD_LAT];
         if (pipe_en[RD_LAT])
            lane_data <= lane_mux_c;
      end
   end

   // clr wins over both a new conflict and a counted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_err <= 1'b0;
         beat_cnt     <= '0;
      end else if (clr) begin
         conflict_err <= 1'b0;
         beat_cnt     <= '0;
      end else begin
         if (BN_MA_in_en && dup_c)
            conflict_err <= 1'b1;
         if (lane_valid && beat_cnt != 16'hFFFF)
            beat_cnt <= beat_cnt + 16'd1;
      end
   end

endmodule
